pal_cfg_loader: RTL and testbench

- Upstream configuration stage for the PAL fabric.
- Accepts the PAL bitstream as bytes over a valid/ready handshake and serialises it LSB-first onto a one-bit config chain, one bit per shift cycle.
- After the last bit it pulses the apply strobe that drives the PAL's EN input.
- Sits between the host-side byte source (pins or SPI front end) and the PAL CFG/EN inputs.

---
 rtl/pal_pkg.sv | 20 ++
 rtl/pal_cfg_shifter.sv | 50 +++++
 rtl/pal_cfg_loader.sv | 123 ++++++++++++
 tb/tb_pal_cfg_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_pkg.sv
// Shared PAL definitions: loader FSM states, byte width and the config-length
// formula used by both the PAL fabric and its loader.
package pal_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_APPLY = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // AND-plane (true and complement per input, per term) plus OR-plane bits.
  function automatic int pal_cfg_len(input int n, input int m, input int p);
    return 2 * n * p + p * m;
  endfunction

endpackage

// File: rtl/pal_cfg_shifter.sv
// Byte-wide parallel-load right shifter. Presents one registered bit per cycle
// for nbits_i cycles after a load and flags the final bit of the byte.
module pal_cfg_shifter
  import pal_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] din_i,
  input  logic [3:0]        nbits_i,
  output logic              bit_o,
  output logic              shift_o,
  output logic              last_o
);

  logic [BYTE_W-1:0] sh_q;
  logic [2:0]        cnt_q;
  logic              bit_q;
  logic              vld_q;

  // cnt_q counts bits still to present after the one currently on bit_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= {BYTE_W{1'b0}};
      cnt_q <= 3'd0;
      bit_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (load_i) begin
      sh_q  <= din_i >> 1;
      cnt_q <= 3'(nbits_i - 4'd1);
      bit_q <= din_i[0];
      vld_q <= 1'b1;
    end else if (vld_q && (cnt_q != 3'd0)) begin
      sh_q  <= sh_q >> 1;
      cnt_q <= cnt_q - 3'd1;
      bit_q <= sh_q[0];
      vld_q <= 1'b1;
    end else begin
      sh_q  <= sh_q;
      cnt_q <= 3'd0;
      bit_q <= 1'b0;
      vld_q <= 1'b0;
    end
  end

  assign bit_o   = bit_q;
  assign shift_o = vld_q;
  assign last_o  = vld_q && (cnt_q == 3'd0);

endmodule

// File: rtl/pal_cfg_loader.sv
// PAL configuration loader: takes bytes over valid/ready, serialises them
// LSB-first onto the config chain and strobes apply after the final bit.
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4,
  parameter int P = 14
) (
  input  logic              CLK,
  input  logic              RES_N,
  input  logic              START,
  input  logic [BYTE_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              CFG_BIT,
  output logic              CFG_SHIFT,
  output logic              CFG_APPLY,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CFG_LEN = pal_cfg_len(N, M, P);
  localparam int CNT_W   = $clog2(CFG_LEN + 1);

  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  logic             ready_q;
  logic             apply_q;
  logic             busy_q;
  logic             done_q;

  logic             byte_xfer;
  logic [3:0]       nbits;
  logic             last_bit;

  // Final byte may be partial: only the remaining bit count is shifted.
  always_comb begin
    byte_xfer = (state_q == S_LOAD) && ready_q && DIN_VALID;
    if (rem_q >= CNT_W'(BYTE_W)) begin
      nbits = 4'(BYTE_W);
    end else begin
      nbits = 4'(rem_q);
    end
  end

  // Control FSM with all handshake and status outputs registered.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q <= S_IDLE;
      rem_q   <= {CNT_W{1'b0}};
      ready_q <= 1'b0;
      apply_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_q <= S_LOAD;
            rem_q   <= CNT_W'(CFG_LEN);
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        S_LOAD: begin
          if (byte_xfer) begin
            state_q <= S_SHIFT;
            ready_q <= 1'b0;
          end else begin
            state_q <= S_LOAD;
          end
        end
        S_SHIFT: begin
          rem_q <= rem_q - CNT_W'(1);
          if (last_bit && (rem_q == CNT_W'(1))) begin
            state_q <= S_APPLY;
            apply_q <= 1'b1;
          end else if (last_bit) begin
            state_q <= S_LOAD;
            ready_q <= 1'b1;
          end else begin
            state_q <= S_SHIFT;
          end
        end
        S_APPLY: begin
          state_q <= S_DONE;
          apply_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          rem_q   <= {CNT_W{1'b0}};
          ready_q <= 1'b0;
          apply_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  pal_cfg_shifter u_shifter (
    .clk_i   (CLK),
    .rst_ni  (RES_N),
    .load_i  (byte_xfer),
    .din_i   (DIN),
    .nbits_i (nbits),
    .bit_o   (CFG_BIT),
    .shift_o (CFG_SHIFT),
    .last_o  (last_bit)
  );

  assign DIN_READY = ready_q;
  assign CFG_APPLY = apply_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Scoreboard bench for pal_cfg_loader: a default 280-bit instance and a
// 21-bit instance exercising the partial final byte.
module tb_pal_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, valid0, start1, valid1;
  logic [7:0] din0, din1;
  logic       ready0, bit0, shift0, apply0, busy0, done0;
  logic       ready1, bit1, shift1, apply1, busy1, done1;

  int total = 0;
  int bad   = 0;

  pal_cfg_loader u_dut (
    .CLK(clk), .RES_N(rst_n), .START(start0), .DIN(din0), .DIN_VALID(valid0),
    .DIN_READY(ready0), .CFG_BIT(bit0), .CFG_SHIFT(shift0), .CFG_APPLY(apply0),
    .BUSY(busy0), .DONE(done0)
  );

  pal_cfg_loader #(.N(3), .M(1), .P(3)) u_dut21 (
    .CLK(clk), .RES_N(rst_n), .START(start1), .DIN(din1), .DIN_VALID(valid1),
    .DIN_READY(ready1), .CFG_BIT(bit1), .CFG_SHIFT(shift1), .CFG_APPLY(apply1),
    .BUSY(busy1), .DONE(done1)
  );

  bit exp0[$], obs0[$], exp1[$], obs1[$];
  int cyc = 0;
  int shifts0, applies0, hs0, stray0, entry0, apply_cyc0;
  int shifts1, applies1, hs1, stray1;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (shift0) begin obs0.push_back(bit0); shifts0++; end
    else if (bit0) stray0++;
    if (apply0) begin applies0++; apply_cyc0 = cyc; if (shift0) stray0++; end
    if (ready0 && valid0) hs0++;
    if (ready0 && entry0 < 0) entry0 = cyc;
    if (shift1) begin obs1.push_back(bit1); shifts1++; end
    else if (bit1) stray1++;
    if (apply1) applies1++;
    if (ready1 && valid1) hs1++;
  end

  task automatic clear_mon();
    exp0.delete(); obs0.delete(); exp1.delete(); obs1.delete();
    shifts0 = 0; applies0 = 0; hs0 = 0; stray0 = 0; entry0 = -1; apply_cyc0 = -1;
    shifts1 = 0; applies1 = 0; hs1 = 0; stray1 = 0;
  endtask

  task automatic pulse_start0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  // Byte source for the default instance; the model pushes expected bits on each handshake.
  task automatic feed0(input int nbytes, input logic [7:0] val, input int stall_after,
                       input bit misuse);
    int sent = 0; int rem = 280; int guard = 0; int n; int s; bit stalled = 1'b0;
    while (sent < nbytes && guard < 5000) begin
      valid0 = 1'b1; din0 = val;
      start0 = misuse && (guard % 7 == 3);
      @(negedge clk); guard++;
      if (ready0) begin
        n = (rem < 8) ? rem : 8;
        for (int b = 0; b < n; b++) exp0.push_back(val[b]);
        rem -= n; sent++;
      end
      @(posedge clk); #1;
      if (!stalled && stall_after > 0 && sent == stall_after) begin
        stalled = 1'b1; valid0 = 1'b0; start0 = 1'b0;
        repeat (10) @(posedge clk); #1;
        s = shifts0;
        repeat (20) @(posedge clk); #1;
        total++;
        if (shifts0 !== s || ready0 !== 1'b1) begin
          bad++; $display("FAIL stall_gap shifts=%0d want %0d ready=%b want 1", shifts0 - s, 0, ready0);
        end
      end
    end
    start0 = 1'b0;
    if (!misuse) valid0 = 1'b0;
    total++;
    if (sent != nbytes) begin bad++; $display("FAIL feed_timeout sent=%0d want %0d", sent, nbytes); end
  endtask

  task automatic wait_done0();
    int g = 0;
    while (!done0 && g < 200) begin @(posedge clk); #1; g++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 0; valid0 = 0; din0 = 0; start1 = 0; valid1 = 0; din1 = 0;
    clear_mon();
    repeat (3) @(negedge clk);
    total++;
    if ({ready0, bit0, shift0, apply0, busy0, done0, ready1, bit1, shift1, apply1, busy1, done1} !== 12'h0) begin
      bad++; $display("FAIL reset_outputs got=%b want 0",
        {ready0, bit0, shift0, apply0, busy0, done0, ready1, bit1, shift1, apply1, busy1, done1});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 start0 = 1'b1;
    @(negedge clk);
    total++;
    if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
      bad++; $display("FAIL ready_early ready=%b busy=%b want 0 0", ready0, busy0);
    end
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    total++;
    if (ready0 !== 1'b1 || busy0 !== 1'b1 || shift0 !== 1'b0) begin
      bad++; $display("FAIL ready_after_start ready=%b busy=%b shift=%b want 1 1 0", ready0, busy0, shift0);
    end
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic check_bits0(input string tag);
    bit e; bit o; int errs = 0;
    while (exp0.size() > 0) begin
      e = exp0.pop_front();
      total++;
      if (obs0.size() == 0) begin bad++; $display("FAIL %s_missing_bit got=none want %b", tag, e); break; end
      o = obs0.pop_front();
      if (o !== e && errs < 5) begin bad++; errs++; $display("FAIL %s_bit got=%b want %b", tag, o, e); end
      else if (o !== e) bad++;
    end
    total++;
    if (obs0.size() != 0) begin bad++; $display("FAIL %s_extra_bits got=%0d want 0", tag, obs0.size()); end
  endtask

  task automatic test_full_load();
    clear_mon();
    pulse_start0();
    feed0(35, 8'hA5, 0, 1'b0);
    wait_done0();
    repeat (3) @(posedge clk); #1;
    check_bits0("full");
    total++;
    if (shifts0 != 280) begin bad++; $display("FAIL full_shift_count got=%0d want 280", shifts0); end
    total++;
    if (applies0 != 1) begin bad++; $display("FAIL full_apply_count got=%0d want 1", applies0); end
    total++;
    if (apply_cyc0 - entry0 + 1 != 316) begin
      bad++; $display("FAIL full_apply_timing got=%0d want 316", apply_cyc0 - entry0 + 1);
    end
    total++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || stray0 != 0) begin
      bad++; $display("FAIL full_status done=%b busy=%b stray=%0d want 1 0 0", done0, busy0, stray0);
    end
  endtask

  task automatic test_stall();
    clear_mon();
    pulse_start0();
    feed0(35, 8'h3C, 12, 1'b0);
    wait_done0();
    repeat (2) @(posedge clk); #1;
    check_bits0("stall");
    total++;
    if (shifts0 != 280 || applies0 != 1) begin
      bad++; $display("FAIL stall_counts shifts=%0d applies=%0d want 280 1", shifts0, applies0);
    end
  endtask

  task automatic test_partial();
    logic [7:0] pat [3];
    int sent = 0; int rem = 21; int guard = 0; int n; bit e; bit o;
    pat[0] = 8'hFF; pat[1] = 8'h00; pat[2] = 8'hFF;
    clear_mon();
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    while (sent < 3 && guard < 200) begin
      valid1 = 1'b1; din1 = pat[sent];
      @(negedge clk); guard++;
      if (ready1) begin
        n = (rem < 8) ? rem : 8;
        for (int b = 0; b < n; b++) exp1.push_back(pat[sent][b]);
        rem -= n; sent++;
      end
      @(posedge clk); #1;
    end
    valid1 = 1'b0;
    repeat (15) @(posedge clk); #1;
    total++;
    if (shifts1 != 21 || applies1 != 1 || hs1 != 3) begin
      bad++; $display("FAIL partial_counts shifts=%0d applies=%0d hs=%0d want 21 1 3", shifts1, applies1, hs1);
    end
    total++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || stray1 != 0) begin
      bad++; $display("FAIL partial_status done=%b busy=%b stray=%0d want 1 0 0", done1, busy1, stray1);
    end
    while (exp1.size() > 0) begin
      e = exp1.pop_front();
      total++;
      if (obs1.size() == 0) begin bad++; $display("FAIL partial_missing_bit got=none want %b", e); break; end
      o = obs1.pop_front();
      if (o !== e) begin bad++; $display("FAIL partial_bit got=%b want %b", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    pulse_start0();
    feed0(10, 8'h5A, 0, 1'b0);
    repeat (3) @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ready0, bit0, shift0, apply0, busy0, done0} !== 6'h0 || applies0 != 0) begin
      bad++; $display("FAIL mid_reset outs=%b applies=%0d want 0 0",
        {ready0, bit0, shift0, apply0, busy0, done0}, applies0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    total++;
    if (applies0 != 0) begin bad++; $display("FAIL mid_no_apply got=%0d want 0", applies0); end
    clear_mon();
    pulse_start0();
    feed0(35, 8'hC3, 0, 1'b0);
    wait_done0();
    repeat (2) @(posedge clk); #1;
    check_bits0("reload");
    total++;
    if (shifts0 != 280 || applies0 != 1) begin
      bad++; $display("FAIL reload_counts shifts=%0d applies=%0d want 280 1", shifts0, applies0);
    end
  endtask

  task automatic test_misuse();
    clear_mon();
    pulse_start0();
    feed0(35, 8'h96, 0, 1'b1);
    wait_done0();
    repeat (20) @(posedge clk); #1;
    valid0 = 1'b0;
    check_bits0("misuse");
    total++;
    if (hs0 != 35 || shifts0 != 280 || applies0 != 1) begin
      bad++; $display("FAIL misuse_counts hs=%0d shifts=%0d applies=%0d want 35 280 1", hs0, shifts0, applies0);
    end
    total++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || ready0 !== 1'b0) begin
      bad++; $display("FAIL misuse_status done=%b busy=%b ready=%b want 1 0 0", done0, busy0, ready0);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_partial();
    test_reset_mid();
    test_misuse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
